// File: rtl/mem_store_buffer.sv
// Store buffer between the MEM stage and the data-memory port. Stores retire
// into a small FIFO and drain in the background; loads forward the youngest matching store.
module mem_store_buffer #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 4,
   parameter int COALESCE = 1
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   req_ren,
   input  logic                   req_wen,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   output logic                   req_hit,
   output logic [DATA_W-1:0]      req_rdata,
   input  logic                   drain_req,
   output logic                   drained,
   input  logic                   dhit,
   input  logic [DATA_W-1:0]      dmemload,
   output logic                   dmemREN,
   output logic                   dmemWEN,
   output logic [ADDR_W-1:0]      dmemaddr,
   output logic [DATA_W-1:0]      dmemstore,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   state_t            state_reg, state_next;
   logic [PTR_W-1:0]  head_reg, tail_reg;
   logic [CNT_W-1:0]  count_reg, count_next;

   logic [DEPTH-1:0]  entry_valid;
   logic [ADDR_W-1:0] entry_addr [DEPTH];
   logic [DATA_W-1:0] entry_data [DEPTH];
   logic [DEPTH-1:0]  match_vec;

   logic              match_any;
   logic [PTR_W-1:0]  match_idx;
   logic [PTR_W-1:0]  scan_idx;
   logic              in_flight;
   logic              coalesce_ok;
   logic              store_ok;
   logic              do_push;
   logic              do_pop;
   logic              do_coalesce;
   logic              fwd_hit;
   logic              load_miss;

   // Per-entry storage: each slot owns its valid/addr/data registers.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic              valid_reg;
         logic [ADDR_W-1:0] addr_reg;
         logic [DATA_W-1:0] data_reg;
         logic              push_sel;
         logic              pop_sel;
         logic              coal_sel;

         assign push_sel = do_push && (tail_reg == PTR_W'(gi));
         assign pop_sel  = do_pop && (head_reg == PTR_W'(gi));
         assign coal_sel = do_coalesce && (match_idx == PTR_W'(gi));

         always_ff @(posedge CLK) begin
            if (RST) begin
               valid_reg <= 1'b0;
               addr_reg  <= '0;
               data_reg  <= '0;
            end else begin
               if (push_sel) begin
                  valid_reg <= 1'b1;
                  addr_reg  <= req_addr;
                  data_reg  <= req_wdata;
               end else if (pop_sel) begin
                  valid_reg <= 1'b0;
               end
               if (coal_sel) begin
                  data_reg <= req_wdata;
               end
            end
         end

         assign entry_valid[gi] = valid_reg;
         assign entry_addr[gi]  = addr_reg;
         assign entry_data[gi]  = data_reg;
         assign match_vec[gi]   = valid_reg &&
                                  (addr_reg[ADDR_W-1:2] == req_addr[ADDR_W-1:2]);
      end
   endgenerate

   // Scan oldest to youngest so the last hit seen is the one closest to tail.
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      scan_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = head_reg + PTR_W'(i);
         if (match_vec[scan_idx]) begin
            match_any = 1'b1;
            match_idx = scan_idx;
         end
      end
   end

   assign in_flight   = (state_reg == WRITE);
   assign coalesce_ok = (COALESCE != 0) && match_any &&
                        !(in_flight && (match_idx == head_reg));
   assign store_ok    = !RST && req_wen && !drain_req &&
                        ((count_reg < FULL_CNT) || coalesce_ok);
   assign do_coalesce = store_ok && coalesce_ok;
   assign do_push     = store_ok && !coalesce_ok;
   assign do_pop      = !RST && in_flight && dhit;
   assign fwd_hit     = req_ren && match_any;
   assign load_miss   = req_ren && !match_any;

   always_comb begin
      count_next = count_reg;
      if (do_push && !do_pop) begin
         count_next = count_reg + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_next = count_reg - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= IDLE;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         if (do_push) begin
            tail_reg <= tail_reg + 1'b1;
         end
         if (do_pop) begin
            head_reg <= head_reg + 1'b1;
         end
      end
   end

   // A pending load miss wins over starting a drain write; an issued write is never preempted.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            if (load_miss) begin
               state_next = READ;
            end else if (count_reg != '0) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            if (dhit) begin
               state_next = IDLE;
            end
         end
         READ: begin
            if (dhit) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      dmemREN   = 1'b0;
      dmemWEN   = 1'b0;
      dmemaddr  = '0;
      dmemstore = '0;
      req_hit   = 1'b0;
      req_rdata = '0;
      if (!RST) begin
         unique case (state_reg)
            WRITE: begin
               dmemWEN   = 1'b1;
               dmemaddr  = entry_addr[head_reg];
               dmemstore = entry_data[head_reg];
            end
            READ: begin
               dmemREN  = 1'b1;
               dmemaddr = req_addr;
            end
            default: ;
         endcase

         if (fwd_hit) begin
            req_hit   = 1'b1;
            req_rdata = entry_data[match_idx];
         end else if ((state_reg == READ) && req_ren && dhit) begin
            req_hit   = 1'b1;
            req_rdata = dmemload;
         end else if (store_ok) begin
            req_hit = 1'b1;
         end
      end
   end

   assign drained = RST || ((count_reg == '0) && (state_reg == IDLE));
   assign count   = count_reg;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: vector table for forwarding/coalescing plus
// hand sequences for full, load-miss, wrap/drain and reset; writes go through a scoreboard.
module tb_mem_store_buffer;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          req_ren, req_wen;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          drain_req, dhit;
   logic [DW-1:0] dmemload;

   logic          req_hit, drained, dmemREN, dmemWEN;
   logic [DW-1:0] req_rdata, dmemstore;
   logic [AW-1:0] dmemaddr;
   logic [2:0]    count;

   logic          nc_req_hit, nc_drained, nc_dmemREN, nc_dmemWEN;
   logic [DW-1:0] nc_req_rdata, nc_dmemstore;
   logic [AW-1:0] nc_dmemaddr;
   logic [2:0]    nc_count;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t exp_wr_q[$];
   wr_t exp_nc_q[$];
   bit  nc_mon_en = 1'b0;

   typedef struct {
      logic          ren;
      logic          wen;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          dh;
      logic          exp_hit;
      logic [DW-1:0] exp_rdata;
      logic [2:0]    exp_count;
      logic          exp_wen;
      logic          exp_drained;
   } vec_t;

   vec_t vecs[12];

   always #5 CLK = ~CLK;

   mem_store_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .COALESCE(1)) dut (
      .CLK(CLK), .RST(RST), .req_ren(req_ren), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_hit(req_hit),
      .req_rdata(req_rdata), .drain_req(drain_req), .drained(drained),
      .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore), .count(count)
   );

   mem_store_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .COALESCE(0)) dut_nc (
      .CLK(CLK), .RST(RST), .req_ren(req_ren), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_hit(nc_req_hit),
      .req_rdata(nc_req_rdata), .drain_req(drain_req), .drained(nc_drained),
      .dhit(dhit), .dmemload(dmemload), .dmemREN(nc_dmemREN), .dmemWEN(nc_dmemWEN),
      .dmemaddr(nc_dmemaddr), .dmemstore(nc_dmemstore), .count(nc_count)
   );

   task automatic check1(input string name, input logic act, input logic exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b, required %0b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic wr_t mkwr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      return w;
   endfunction

   function automatic vec_t mk(input logic ren, input logic wen, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic dh, input logic eh,
                               input logic [DW-1:0] erd, input logic [2:0] ec,
                               input logic ew, input logic ed);
      vec_t v;
      v.ren = ren; v.wen = wen; v.addr = addr; v.wdata = wdata; v.dh = dh;
      v.exp_hit = eh; v.exp_rdata = erd; v.exp_count = ec; v.exp_wen = ew; v.exp_drained = ed;
      return v;
   endfunction

   // Write scoreboard: every completed memory write is popped against the expected queue.
   always @(negedge CLK) begin
      wr_t e;
      if (!RST && dmemWEN && dhit) begin
         if (exp_wr_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, required none", dmemaddr, dmemstore);
         end else begin
            e = exp_wr_q.pop_front();
            check32("wr_addr", dmemaddr, e.addr);
            check32("wr_data", dmemstore, e.data);
            $display("write addr=0x%0h data=0x%0h", dmemaddr, dmemstore);
         end
      end
      if (nc_mon_en && !RST && nc_dmemWEN && dhit) begin
         if (exp_nc_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL nc_unexpected_write: got addr=0x%0h data=0x%0h, required none", nc_dmemaddr, nc_dmemstore);
         end else begin
            e = exp_nc_q.pop_front();
            check32("nc_wr_addr", nc_dmemaddr, e.addr);
            check32("nc_wr_data", nc_dmemstore, e.data);
            $display("nc write addr=0x%0h data=0x%0h", nc_dmemaddr, nc_dmemstore);
         end
      end
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset;
      RST = 1'b1; req_ren = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
      dhit = 1'b0; drain_req = 1'b0; dmemload = '0;
      repeat (2) tick;
      @(negedge CLK);
      check1("rst_drained", drained, 1'b1);
      check32("rst_count", 32'(count), 32'd0);
      check1("rst_dmemREN", dmemREN, 1'b0);
      check1("rst_dmemWEN", dmemWEN, 1'b0);
      check1("rst_req_hit", req_hit, 1'b0);
      tick;
      RST = 1'b0;
      $display("reset done");
   endtask

   task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic eh,
                           input string name);
      req_wen = 1'b1; req_addr = a; req_wdata = d;
      @(negedge CLK);
      check1(name, req_hit, eh);
      $display("store addr=0x%0h data=0x%0h hit=%0b", a, d, req_hit);
      tick;
      req_wen = 1'b0;
   endtask

   task automatic do_pop(input string tag);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (dmemWEN) seen = 1'b1;
         else tick;
      end
      n_assert++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s_pop_timeout: dmemWEN=%0b, required 1", tag, dmemWEN);
      end else begin
         dhit = 1'b1;
         tick;
         dhit = 1'b0;
      end
   endtask

   task automatic wait_drained(input string tag, input bit both);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         tick;
         done = drained && (!both || nc_drained);
      end
      @(negedge CLK);
      check1({tag, "_drained"}, drained, 1'b1);
      check32({tag, "_count"}, 32'(count), 32'd0);
      if (both) check1({tag, "_nc_drained"}, nc_drained, 1'b1);
      tick;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1'b0, 32'h0,    3'd0, 1'b0, 1'b1);
      vecs[1]  = mk(1'b0, 1'b1, 32'h100, 32'hAAAA, 1'b0, 1'b1, 32'h0,    3'd0, 1'b0, 1'b1);
      vecs[2]  = mk(1'b1, 1'b0, 32'h102, 32'h0,    1'b0, 1'b1, 32'hAAAA, 3'd1, 1'b0, 1'b0);
      vecs[3]  = mk(1'b1, 1'b0, 32'h100, 32'h0,    1'b0, 1'b1, 32'hAAAA, 3'd1, 1'b1, 1'b0);
      vecs[4]  = mk(1'b0, 1'b1, 32'h100, 32'hBBBB, 1'b0, 1'b1, 32'h0,    3'd1, 1'b1, 1'b0);
      vecs[5]  = mk(1'b1, 1'b0, 32'h100, 32'h0,    1'b0, 1'b1, 32'hBBBB, 3'd2, 1'b1, 1'b0);
      vecs[6]  = mk(1'b0, 1'b1, 32'h100, 32'hCCCC, 1'b0, 1'b1, 32'h0,    3'd2, 1'b1, 1'b0);
      vecs[7]  = mk(1'b1, 1'b0, 32'h103, 32'h0,    1'b0, 1'b1, 32'hCCCC, 3'd2, 1'b1, 1'b0);
      vecs[8]  = mk(1'b0, 1'b0, 32'h0,   32'h0,    1'b1, 1'b0, 32'h0,    3'd2, 1'b1, 1'b0);
      vecs[9]  = mk(1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1'b0, 32'h0,    3'd1, 1'b0, 1'b0);
      vecs[10] = mk(1'b0, 1'b0, 32'h0,   32'h0,    1'b1, 1'b0, 32'h0,    3'd1, 1'b1, 1'b0);
      vecs[11] = mk(1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1'b0, 32'h0,    3'd0, 1'b0, 1'b1);

      // Table: forward, in-flight head, youngest-wins, coalesce, background drain.
      do_reset;
      exp_wr_q.push_back(mkwr(32'h100, 32'hAAAA));
      exp_wr_q.push_back(mkwr(32'h100, 32'hCCCC));
      for (int i = 0; i < 12; i++) begin
         req_ren = vecs[i].ren; req_wen = vecs[i].wen; req_addr = vecs[i].addr;
         req_wdata = vecs[i].wdata; dhit = vecs[i].dh;
         @(negedge CLK);
         check1($sformatf("vec%0d_hit", i), req_hit, vecs[i].exp_hit);
         check32($sformatf("vec%0d_rdata", i), req_rdata, vecs[i].exp_rdata);
         check32($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
         check1($sformatf("vec%0d_dmemWEN", i), dmemWEN, vecs[i].exp_wen);
         check1($sformatf("vec%0d_dmemREN", i), dmemREN, 1'b0);
         check1($sformatf("vec%0d_drained", i), drained, vecs[i].exp_drained);
         $display("vec%0d hit=%0b rdata=0x%0h count=%0d", i, req_hit, req_rdata, count);
         tick;
      end
      req_ren = 1'b0; req_wen = 1'b0; dhit = 1'b0;

      // Fill, stall on full, late acceptance after a pop.
      do_reset;
      for (int i = 0; i < 4; i++) begin
         do_store(32'(i * 4), 32'h1000 + 32'(i), 1'b1, "fill_hit");
         exp_wr_q.push_back(mkwr(32'(i * 4), 32'h1000 + 32'(i)));
      end
      @(negedge CLK);
      check32("fill_count", 32'(count), 32'd4);
      tick;
      req_wen = 1'b1; req_addr = 32'h10; req_wdata = 32'h1010;
      @(negedge CLK);
      check1("full_stall_hit", req_hit, 1'b0);
      tick;
      dhit = 1'b1;
      @(negedge CLK);
      check1("full_pop_cycle_hit", req_hit, 1'b0);
      check1("full_pop_wen", dmemWEN, 1'b1);
      tick;
      dhit = 1'b0;
      @(negedge CLK);
      check1("full_accept_hit", req_hit, 1'b1);
      tick;
      req_wen = 1'b0;
      exp_wr_q.push_back(mkwr(32'h10, 32'h1010));
      @(negedge CLK);
      check32("full_accept_count", 32'(count), 32'd4);
      tick;
      dhit = 1'b1;
      wait_drained("fill", 1'b0);
      dhit = 1'b0;

      // Coalesce on vs off.
      do_reset;
      nc_mon_en = 1'b1;
      do_store(32'h20, 32'h1, 1'b1, "coal_st1");
      do_store(32'h20, 32'h2, 1'b1, "coal_st2");
      @(negedge CLK);
      check32("coal_count", 32'(count), 32'd1);
      check32("nocoal_count", 32'(nc_count), 32'd2);
      exp_wr_q.push_back(mkwr(32'h20, 32'h2));
      exp_nc_q.push_back(mkwr(32'h20, 32'h1));
      exp_nc_q.push_back(mkwr(32'h20, 32'h2));
      tick;
      dhit = 1'b1;
      wait_drained("coal", 1'b1);
      dhit = 1'b0;
      check32("nc_queue_left", 32'(exp_nc_q.size()), 32'd0);
      nc_mon_en = 1'b0;

      // Load miss waits behind an issued write, then reads memory.
      do_reset;
      do_store(32'h40, 32'h5555, 1'b1, "lm_st");
      exp_wr_q.push_back(mkwr(32'h40, 32'h5555));
      tick;
      req_ren = 1'b1; req_addr = 32'h80; dmemload = 32'h1234;
      @(negedge CLK);
      check1("lm_wait_hit", req_hit, 1'b0);
      check1("lm_wait_wen", dmemWEN, 1'b1);
      check1("lm_wait_ren", dmemREN, 1'b0);
      tick;
      dhit = 1'b1;
      @(negedge CLK);
      check1("lm_wdone_hit", req_hit, 1'b0);
      tick;
      dhit = 1'b0;
      @(negedge CLK);
      check1("lm_idle_ren", dmemREN, 1'b0);
      tick;
      @(negedge CLK);
      check1("lm_read_ren", dmemREN, 1'b1);
      check32("lm_read_addr", dmemaddr, 32'h80);
      check1("lm_read_nohit", req_hit, 1'b0);
      tick;
      dhit = 1'b1;
      @(negedge CLK);
      check1("lm_done_hit", req_hit, 1'b1);
      check32("lm_done_rdata", req_rdata, 32'h1234);
      $display("load addr=0x80 rdata=0x%0h", req_rdata);
      tick;
      dhit = 1'b0; req_ren = 1'b0;
      @(negedge CLK);
      check1("lm_end_drained", drained, 1'b1);
      tick;

      // Pointer wrap with interleaved pops, then drain with a rejected store.
      do_reset;
      for (int i = 0; i < 3; i++) begin
         do_store(32'h200 + 32'(i * 4), 32'hD00 + 32'(i), 1'b1, "wrap_st");
         exp_wr_q.push_back(mkwr(32'h200 + 32'(i * 4), 32'hD00 + 32'(i)));
      end
      do_pop("wrap0");
      do_pop("wrap1");
      for (int i = 3; i < 6; i++) begin
         do_store(32'h200 + 32'(i * 4), 32'hD00 + 32'(i), 1'b1, "wrap_st");
         exp_wr_q.push_back(mkwr(32'h200 + 32'(i * 4), 32'hD00 + 32'(i)));
      end
      do_pop("wrap2");
      @(negedge CLK);
      check32("wrap_count", 32'(count), 32'd3);
      tick;
      drain_req = 1'b1;
      req_wen = 1'b1; req_addr = 32'h300; req_wdata = 32'hEEE;
      @(negedge CLK);
      check1("drain_store_hit", req_hit, 1'b0);
      tick;
      req_wen = 1'b0;
      dhit = 1'b1;
      wait_drained("drain", 1'b0);
      dhit = 1'b0; drain_req = 1'b0;

      // Reset during an issued write beats dhit.
      do_reset;
      do_store(32'h60, 32'h7, 1'b1, "rw_st");
      tick;
      @(negedge CLK);
      check1("rw_in_write", dmemWEN, 1'b1);
      tick;
      RST = 1'b1; dhit = 1'b1;
      @(negedge CLK);
      check1("rw_rst_wen", dmemWEN, 1'b0);
      tick;
      RST = 1'b0; dhit = 1'b0;
      @(negedge CLK);
      check32("rw_count", 32'(count), 32'd0);
      check1("rw_drained", drained, 1'b1);
      tick;
      tick;
      @(negedge CLK);
      check1("rw_no_reissue", dmemWEN, 1'b0);

      check32("wr_queue_left", 32'(exp_wr_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- Parametrised successor to the single-request memory stage.
- Sits between the MEM pipeline stage and the data-memory port (dcache/arbiter), behind a DEPTH-entry FIFO store buffer.
- Stores retire to the pipeline immediately while the buffer has room, and drain to memory in the background.
- Loads check the buffer first and forward the youngest matching store; on a miss they go to memory.
- Optional coalescing merges repeat stores to the same word.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- DEPTH, 4, store-buffer entries; power of two, minimum 2.
- COALESCE, 1, 1 = a store to an already-buffered, non-in-flight address overwrites that entry in place.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- req_ren  in  1  pipeline load request
- req_wen  in  1  pipeline store request; req_ren and req_wen are never both high
- req_addr  in  ADDR_W  request byte address; word-compare ignores bits [1:0]
- req_wdata  in  DATA_W  store data
- req_hit  out  1  request completed this cycle; pipeline stalls while a request is high and req_hit is low
- req_rdata  out  DATA_W  load data, valid when req_hit and req_ren are both high
- drain_req  in  1  halt/flush: stop accepting stores and empty the buffer
- drained  out  1  buffer empty and no memory transaction outstanding
- dhit  in  1  memory completed the current transaction
- dmemload  in  DATA_W  memory read data
- dmemREN  out  1  memory read
- dmemWEN  out  1  memory write
- dmemaddr  out  ADDR_W  memory address
- dmemstore  out  DATA_W  memory write data
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Storage: circular FIFO with per-entry valid, addr and data, plus head/tail pointers of $clog2(DEPTH) bits each; pointers wrap modulo DEPTH.
- Reset: when RST is high at a posedge:
  - all valids, head, tail and count clear to 0;
  - FSM goes to IDLE;
  - any in-flight transaction is abandoned.
- Outputs while in reset/IDLE: dmemREN=0, dmemWEN=0, dmemaddr=0, dmemstore=0, req_hit=0, req_rdata=0, drained=1.
- FSM states: IDLE, WRITE, READ. The memory request is held stable until dhit.
  - IDLE→READ: a load misses the buffer.
  - IDLE→WRITE: no load miss pending and count>0. Head is issued.
  - READ: dmemREN=1, dmemaddr=req_addr. On dhit: req_hit=1, req_rdata=dmemload (combinational, same cycle); next state IDLE.
  - WRITE: dmemWEN=1, addr/data taken from head. On dhit: pop head, head advances, next state IDLE. A waiting load miss is serviced after the write completes (no preemption).
- Load forward: match = valid entry with addr[ADDR_W-1:2] equal. The youngest match (closest to tail) wins. req_hit=1 and req_rdata=entry data in the same cycle, with zero latency and no memory access. This applies in any state, including when the matching entry is the in-flight head.
- Store accept: req_hit=1 in the same cycle when any of the following holds (and drain_req=0):
  - count<DEPTH; or
  - COALESCE=1 and a matching entry exists that is not the in-flight head.
- Coalesce hit: overwrite the youngest matching entry's data; count is unchanged.
- Otherwise the store allocates the tail entry and count increments.
- Full: when count==DEPTH and the store does not coalesce, req_hit=0. Full is evaluated on the registered count, so a pop in the same cycle does not admit the store; it is accepted the following cycle.
- Simultaneous pop and push: count is unchanged, head and tail both advance.
- Ordering: loads may bypass older buffered stores to other words; same-word ordering is preserved by forwarding.
- Drain: while drain_req=1, stores get req_hit=0 and loads behave normally. drained = (count==0 && state==IDLE).
- Reset during WRITE or READ takes priority over dhit in the same cycle.

Test Plan:
- Reset, idle: RST high for 2 cycles → count=0, drained=1, dmemREN=dmemWEN=0, req_hit=0.
- Store then forward: store 0x100←0xAAAA, with dhit held low → req_hit=1 the same cycle, count=1. Then load 0x102 → req_hit=1, req_rdata=0xAAAA, dmemREN=0.
- Fill and stall (DEPTH=4, dhit=0): stores to 0x0, 0x4, 0x8, 0xC → count=4. A 5th store to 0x10 gets req_hit=0. Raise dhit for 1 cycle → head 0x0 is written; the store is accepted on the next cycle with count=4.
- Coalesce: store 0x20←1 then 0x20←2 (not in flight) → count=1. The later drain writes dmemaddr=0x20, dmemstore=2. With COALESCE=0 → count=2 and the two writes occur in order 1, 2.
- Load miss during drain: buffer holds 0x40, FSM in WRITE; load 0x80 → waits until the write's dhit, then READ with dmemREN=1, dmemaddr=0x80; dmemload=0x1234 on dhit → req_rdata=0x1234.
- Drain and wrap: 6 stores interleaved with pops (pointer wrap), then drain_req=1 → all entries written in FIFO order, drained=1 after the last dhit, and a new store during drain gets req_hit=0.
